// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the bit-serial ALU sequencer.
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ADD and SUB are the only ops whose carry and overflow are meaningful.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Front-end request/response bundle of the serial ALU sequencer.
interface serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, ovf
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: feeds one WIDTH-bit op through an external 1-bit ALU slice, LSB first,
// recirculating the slice carry between bits.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_alu_ctrl_if.slave bus,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c_in,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_c_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sh, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_out_q, ovf_q;
  logic             accept, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        accept = bus.start;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        last = (cnt == CW'(WIDTH - 1));
        if (last) state_nxt = DONE;
      end
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // carry still holds the carry into the MSB while the MSB is in the slice,
  // so overflow needs no separate capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sh   <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      op_q  <= bus.op;
      cnt   <= '0;
      carry <= (bus.op == OP_SUB);
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sh <= {alu_result, res_sh[WIDTH-1:1]};
      carry  <= alu_c_out;
      cnt    <= cnt + CW'(1);
      if (last) begin
        result_q <= {alu_result, res_sh[WIDTH-1:1]};
        c_out_q  <= is_arith(op_q) & alu_c_out;
        ovf_q    <= is_arith(op_q) & (carry ^ alu_c_out);
      end
    end
  end

  assign alu_a    = (state == RUN) & a_sr[0];
  assign alu_b    = (state == RUN) & b_sr[0];
  assign alu_c_in = (state == RUN) & carry;
  assign alu_op   = (state == RUN) ? op_q : 3'b000;

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
  assign bus.ovf    = ovf_q;

endmodule
